// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    localparam int         c_DST_W    = 5;
    localparam logic [4:0] c_REG_ZERO = 5'd0;

    typedef struct packed {
        logic               v;
        logic [c_DST_W-1:0] dst;
    } sb_entry_t;

    typedef enum logic [0:0] {
        HZ_IDLE   = 1'b0,
        HZ_SQUASH = 1'b1
    } hz_state_t;

    function automatic logic entry_hit(input sb_entry_t e, input logic [c_DST_W-1:0] r);
        return e.v && (e.dst == r);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_scoreboard
// Description : EX/MEM/WB destination shift register with two RAW compare ports.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RF_WRITE_THRU = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_v,
    input  logic [c_DST_W-1:0] push_dst,
    input  logic [c_DST_W-1:0] rd_a,
    input  logic [c_DST_W-1:0] rd_b,
    output logic               hit_a,
    output logic               hit_b
);

    sb_entry_t r_ex;
    sb_entry_t r_mem;
    sb_entry_t r_wb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= '{v: push_v, dst: push_dst};
        end
    end

    // With write-through the register file already holds the WB value when ID reads it.
    assign hit_a = (rd_a != c_REG_ZERO) &&
                   (entry_hit(r_ex, rd_a) || entry_hit(r_mem, rd_a) ||
                    ((RF_WRITE_THRU == 0) && entry_hit(r_wb, rd_a)));

    assign hit_b = (rd_b != c_REG_ZERO) &&
                   (entry_hit(r_ex, rd_b) || entry_hit(r_mem, rd_b) ||
                    ((RF_WRITE_THRU == 0) && entry_hit(r_wb, rd_b)));

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : RAW stall, branch/jump squash control and perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CTRL_SLOTS    = 1,
    parameter int RF_WRITE_THRU = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wreg,
    input  logic [4:0]       id_wdst,
    input  logic             id_is_jump,
    input  logic             id_is_branch,
    input  logic             id_br_taken,
    output logic             id_wpcir,
    output logic             jmp_stall,
    output logic             ctrl_branch,
    output logic             ex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    localparam logic [1:0] c_SQUASH_INIT = 2'(CTRL_SLOTS - 1);

    hz_state_t        r_state;
    hz_state_t        w_state_nxt;
    logic [1:0]       r_cnt;
    logic [1:0]       w_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_squash_cnt;

    logic w_squash;
    logic w_hit_rs;
    logic w_hit_rt;
    logic w_hazard;
    logic w_issue;
    logic w_redirect;

    pipe_hazard_ctrl_scoreboard #(
        .RF_WRITE_THRU (RF_WRITE_THRU)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .push_v   (w_issue & id_wreg & (id_wdst != c_REG_ZERO)),
        .push_dst (id_wdst),
        .rd_a     (id_rs),
        .rd_b     (id_rt),
        .hit_a    (w_hit_rs),
        .hit_b    (w_hit_rt)
    );

    assign w_squash   = (r_state == HZ_SQUASH);
    assign w_hazard   = id_valid & ~w_squash &
                        ((id_use_rs & w_hit_rs) | (id_use_rt & w_hit_rt));
    assign w_issue    = id_valid & ~w_hazard & ~w_squash;
    // A stalled branch cannot redirect: its operands are not ready yet.
    assign w_redirect = w_issue & (id_is_jump | (id_is_branch & id_br_taken));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HZ_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            HZ_IDLE: begin
                if (w_redirect) begin
                    w_state_nxt = HZ_SQUASH;
                    w_cnt_nxt   = c_SQUASH_INIT;
                end
            end
            HZ_SQUASH: begin
                if (r_cnt == 2'd0) begin
                    w_state_nxt = HZ_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            default: begin
                w_state_nxt = HZ_IDLE;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_squash_cnt <= '0;
        end else begin
            if (w_hazard) r_stall_cnt  <= r_stall_cnt + CNT_W'(1);
            if (w_squash) r_squash_cnt <= r_squash_cnt + CNT_W'(1);
        end
    end

    assign id_wpcir    = w_hazard;
    assign jmp_stall   = w_squash;
    assign ctrl_branch = w_redirect;
    assign ex_bubble   = w_hazard | w_squash;
    assign stall_cnt   = r_stall_cnt;
    assign squash_cnt  = r_squash_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Two parameterisations driven in lockstep, checked against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic       urs;
        logic [4:0] rt;
        logic       urt;
        logic       wr;
        logic [4:0] dst;
        logic       jmp;
        logic       br;
        logic       tk;
    } ins_t;

    // Index 0: CTRL_SLOTS=1, RF_WRITE_THRU=1. Index 1: CTRL_SLOTS=3, RF_WRITE_THRU=0.
    localparam int WIN   [2] = '{2, 3};
    localparam int SLOTS [2] = '{1, 3};

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_use_rs, id_use_rt, id_wreg;
    logic       id_is_jump, id_is_branch, id_br_taken;
    logic [4:0] id_rs, id_rt, id_wdst;

    logic [1:0]  wpcir, jstall, cbr, bub;
    logic [15:0] scnt [2];
    logic [15:0] qcnt [2];

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: per-register cycle of the last issued write.
    int last_wr [2][32];
    int sq_left [2];
    int m_stall [2];
    int m_squash[2];
    int cyc = 0;
    bit e_haz[2], e_sq[2], e_br[2], e_bub[2], e_issue[2];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CTRL_SLOTS(1), .RF_WRITE_THRU(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_wdst(id_wdst),
        .id_is_jump(id_is_jump), .id_is_branch(id_is_branch), .id_br_taken(id_br_taken),
        .id_wpcir(wpcir[0]), .jmp_stall(jstall[0]), .ctrl_branch(cbr[0]), .ex_bubble(bub[0]),
        .stall_cnt(scnt[0]), .squash_cnt(qcnt[0])
    );

    pipe_hazard_ctrl #(.CTRL_SLOTS(3), .RF_WRITE_THRU(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_wdst(id_wdst),
        .id_is_jump(id_is_jump), .id_is_branch(id_is_branch), .id_br_taken(id_br_taken),
        .id_wpcir(wpcir[1]), .jmp_stall(jstall[1]), .ctrl_branch(cbr[1]), .ex_bubble(bub[1]),
        .stall_cnt(scnt[1]), .squash_cnt(qcnt[1])
    );

    function automatic ins_t mk_nop();
        ins_t i = '0;
        return i;
    endfunction

    function automatic ins_t mk_alu(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
        ins_t i = '0;
        i.v = 1'b1; i.rs = rs; i.urs = 1'b1; i.rt = rt; i.urt = 1'b1; i.wr = 1'b1; i.dst = dst;
        return i;
    endfunction

    function automatic ins_t mk_br(input logic [4:0] rs, input logic taken);
        ins_t i = '0;
        i.v = 1'b1; i.rs = rs; i.urs = 1'b1; i.br = 1'b1; i.tk = taken;
        return i;
    endfunction

    function automatic ins_t mk_jmp();
        ins_t i = '0;
        i.v = 1'b1; i.jmp = 1'b1;
        return i;
    endfunction

    function automatic bit hit(input int m, input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        return (cyc - last_wr[m][r]) <= WIN[m];
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < 32; r++) last_wr[m][r] = -1000;
            sq_left[m]  = 0;
            m_stall[m]  = 0;
            m_squash[m] = 0;
        end
    endtask

    task automatic model_eval();
        for (int m = 0; m < 2; m++) begin
            e_sq[m]    = (sq_left[m] > 0);
            e_haz[m]   = id_valid && !e_sq[m] &&
                         ((id_use_rs && hit(m, id_rs)) || (id_use_rt && hit(m, id_rt)));
            e_issue[m] = id_valid && !e_sq[m] && !e_haz[m];
            e_br[m]    = e_issue[m] && (id_is_jump || (id_is_branch && id_br_taken));
            e_bub[m]   = e_haz[m] || e_sq[m];
        end
    endtask

    task automatic model_commit();
        if (rst) begin
            model_reset();
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (e_issue[m] && id_wreg && id_wdst != 5'd0) last_wr[m][id_wdst] = cyc;
                if (e_haz[m]) m_stall[m]  = (m_stall[m] + 1) % 65536;
                if (e_sq[m])  m_squash[m] = (m_squash[m] + 1) % 65536;
                if (e_sq[m])       sq_left[m] = sq_left[m] - 1;
                else if (e_br[m])  sq_left[m] = SLOTS[m];
            end
        end
        cyc++;
    endtask

    task automatic drive(input logic r, input ins_t i);
        @(negedge clk);
        rst          = r;
        id_valid     = i.v;
        id_rs        = i.rs;
        id_use_rs    = i.urs;
        id_rt        = i.rt;
        id_use_rt    = i.urt;
        id_wreg      = i.wr;
        id_wdst      = i.dst;
        id_is_jump   = i.jmp;
        id_is_branch = i.br;
        id_br_taken  = i.tk;
        #1;
        model_eval();
    endtask

    task automatic step();
        @(posedge clk);
        model_commit();
    endtask

    task automatic do_reset();
        drive(1'b1, mk_nop());
        step();
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, mk_nop());
        for (int m = 0; m < 2; m++) begin
            tests_run += 4;
            if ({wpcir[m], jstall[m], cbr[m], bub[m]} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset_outs dut%0d: got %b want 0000", m, {wpcir[m], jstall[m], cbr[m], bub[m]});
            end
            if (scnt[m] !== 16'd0) begin
                tests_failed++;
                $display("FAIL reset_stall_cnt dut%0d: got %0d want 0", m, scnt[m]);
            end
            if (qcnt[m] !== 16'd0) begin
                tests_failed++;
                $display("FAIL reset_squash_cnt dut%0d: got %0d want 0", m, qcnt[m]);
            end
        end
        step();
    endtask

    task automatic test_raw_stall();
        int  first_go[2] = '{-1, -1};
        bit  bub_ok[2]   = '{1'b1, 1'b1};
        do_reset();
        drive(1'b0, mk_alu(5'd3, 5'd1, 5'd2));
        step();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, mk_alu(5'd4, 5'd3, 5'd1));
            for (int m = 0; m < 2; m++) begin
                if (first_go[m] < 0) begin
                    if (wpcir[m] === 1'b0) begin
                        first_go[m] = k;
                        tests_run++;
                        if (scnt[m] !== 16'(WIN[m])) begin
                            tests_failed++;
                            $display("FAIL raw_stall_cnt dut%0d: got %0d want %0d", m, scnt[m], WIN[m]);
                        end
                    end else if (bub[m] !== 1'b1) begin
                        bub_ok[m] = 1'b0;
                    end
                end
            end
            step();
        end
        for (int m = 0; m < 2; m++) begin
            tests_run += 2;
            if (first_go[m] != WIN[m]) begin
                tests_failed++;
                $display("FAIL raw_stall_len dut%0d: got %0d want %0d", m, first_go[m], WIN[m]);
            end
            if (!bub_ok[m]) begin
                tests_failed++;
                $display("FAIL raw_bubble dut%0d: got 0 want 1 during stall", m);
            end
        end
        // Register zero is never a hazard.
        drive(1'b0, mk_alu(5'd0, 5'd1, 5'd2));
        step();
        drive(1'b0, mk_alu(5'd6, 5'd0, 5'd0));
        for (int m = 0; m < 2; m++) begin
            tests_run++;
            if (wpcir[m] !== 1'b0) begin
                tests_failed++;
                $display("FAIL r0_no_stall dut%0d: got %b want 0", m, wpcir[m]);
            end
        end
        step();
    endtask

    task automatic test_branch();
        ins_t rd;
        do_reset();
        drive(1'b0, mk_alu(5'd7, 5'd1, 5'd2));
        step();
        drive(1'b0, mk_br(5'd0, 1'b1));
        for (int m = 0; m < 2; m++) begin
            tests_run++;
            if (cbr[m] !== 1'b1 || jstall[m] !== 1'b0) begin
                tests_failed++;
                $display("FAIL beq_taken dut%0d: got br=%b js=%b want br=1 js=0", m, cbr[m], jstall[m]);
            end
        end
        step();
        rd = mk_alu(5'd8, 5'd7, 5'd7);
        rd.jmp = 1'b1;
        drive(1'b0, rd);
        for (int m = 0; m < 2; m++) begin
            tests_run++;
            if ({wpcir[m], jstall[m], cbr[m], bub[m]} !== 4'b0101) begin
                tests_failed++;
                $display("FAIL squash_slot dut%0d: got %b want 0101", m, {wpcir[m], jstall[m], cbr[m], bub[m]});
            end
        end
        step();
        drive(1'b0, mk_nop());
        tests_run += 3;
        if (jstall[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL squash_end dut0: got %b want 0", jstall[0]);
        end
        if (qcnt[0] !== 16'd1) begin
            tests_failed++;
            $display("FAIL squash_cnt dut0: got %0d want 1", qcnt[0]);
        end
        if (jstall[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL squash_slot2 dut1: got %b want 1", jstall[1]);
        end
        step();
        drive(1'b0, mk_nop());
        step();
        drive(1'b0, mk_br(5'd0, 1'b0));
        for (int m = 0; m < 2; m++) begin
            tests_run++;
            if (cbr[m] !== 1'b0 || jstall[m] !== 1'b0) begin
                tests_failed++;
                $display("FAIL beq_untaken dut%0d: got br=%b js=%b want 0 0", m, cbr[m], jstall[m]);
            end
        end
        step();
        drive(1'b0, mk_nop());
        for (int m = 0; m < 2; m++) begin
            tests_run++;
            if (jstall[m] !== 1'b0) begin
                tests_failed++;
                $display("FAIL untaken_no_squash dut%0d: got %b want 0", m, jstall[m]);
            end
        end
        step();
    endtask

    task automatic test_jump();
        do_reset();
        drive(1'b0, mk_jmp());
        for (int m = 0; m < 2; m++) begin
            tests_run++;
            if (cbr[m] !== 1'b1) begin
                tests_failed++;
                $display("FAIL jmp_redirect dut%0d: got %b want 1", m, cbr[m]);
            end
        end
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, mk_jmp());
            tests_run++;
            if (jstall[1] !== 1'b1 || cbr[1] !== 1'b0) begin
                tests_failed++;
                $display("FAIL jmp_slot%0d dut1: got js=%b br=%b want js=1 br=0", k, jstall[1], cbr[1]);
            end
            step();
        end
        drive(1'b0, mk_nop());
        tests_run += 2;
        if (jstall[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL jmp_squash_len dut1: got %b want 0 after 3 slots", jstall[1]);
        end
        if (qcnt[1] !== 16'd3) begin
            tests_failed++;
            $display("FAIL jmp_squash_cnt dut1: got %0d want 3", qcnt[1]);
        end
        step();
    endtask

    task automatic test_branch_hazard();
        int first_go[2] = '{-1, -1};
        do_reset();
        drive(1'b0, mk_alu(5'd5, 5'd1, 5'd0));
        step();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, mk_br(5'd5, 1'b1));
            for (int m = 0; m < 2; m++) begin
                if (first_go[m] < 0) begin
                    tests_run++;
                    if (wpcir[m] === 1'b0) begin
                        first_go[m] = k;
                        if (cbr[m] !== 1'b1) begin
                            tests_failed++;
                            $display("FAIL bne_resolve dut%0d: got %b want 1", m, cbr[m]);
                        end
                    end else if (cbr[m] !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL bne_hold dut%0d k=%0d: got %b want 0", m, k, cbr[m]);
                    end
                end
            end
            step();
        end
        for (int m = 0; m < 2; m++) begin
            tests_run++;
            if (first_go[m] != WIN[m]) begin
                tests_failed++;
                $display("FAIL bne_stall_len dut%0d: got %0d want %0d", m, first_go[m], WIN[m]);
            end
        end
    endtask

    task automatic test_reset_mid_squash();
        ins_t j;
        do_reset();
        drive(1'b0, mk_alu(5'd9, 5'd1, 5'd2));
        step();
        j = mk_jmp();
        j.wr = 1'b1;
        j.dst = 5'd10;
        drive(1'b0, j);
        step();
        drive(1'b1, mk_nop());
        for (int m = 0; m < 2; m++) begin
            tests_run++;
            if (jstall[m] !== 1'b1) begin
                tests_failed++;
                $display("FAIL pre_reset_squash dut%0d: got %b want 1", m, jstall[m]);
            end
        end
        step();
        drive(1'b0, mk_alu(5'd11, 5'd9, 5'd10));
        for (int m = 0; m < 2; m++) begin
            tests_run += 2;
            if ({wpcir[m], jstall[m], cbr[m], bub[m]} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL post_reset_outs dut%0d: got %b want 0000", m, {wpcir[m], jstall[m], cbr[m], bub[m]});
            end
            if (scnt[m] !== 16'd0 || qcnt[m] !== 16'd0) begin
                tests_failed++;
                $display("FAIL post_reset_cnts dut%0d: got %0d/%0d want 0/0", m, scnt[m], qcnt[m]);
            end
        end
        step();
    endtask

    task automatic test_random();
        ins_t i;
        logic r;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            r       = ($urandom_range(0, 60) == 0);
            i       = '0;
            i.v     = ($urandom_range(0, 7) != 0);
            i.rs    = 5'($urandom_range(0, 7));
            i.rt    = 5'($urandom_range(0, 7));
            i.urs   = 1'($urandom);
            i.urt   = 1'($urandom);
            i.wr    = 1'($urandom);
            i.dst   = 5'($urandom_range(0, 7));
            i.jmp   = ($urandom_range(0, 9) == 0);
            i.br    = ($urandom_range(0, 5) == 0);
            i.tk    = 1'($urandom);
            drive(r, i);
            for (int m = 0; m < 2; m++) begin
                tests_run += 6;
                if (wpcir[m] !== e_haz[m]) begin
                    tests_failed++;
                    $display("FAIL rand_wpcir dut%0d n=%0d: got %b want %b", m, n, wpcir[m], e_haz[m]);
                end
                if (jstall[m] !== e_sq[m]) begin
                    tests_failed++;
                    $display("FAIL rand_jmp_stall dut%0d n=%0d: got %b want %b", m, n, jstall[m], e_sq[m]);
                end
                if (cbr[m] !== e_br[m]) begin
                    tests_failed++;
                    $display("FAIL rand_ctrl_branch dut%0d n=%0d: got %b want %b", m, n, cbr[m], e_br[m]);
                end
                if (bub[m] !== e_bub[m]) begin
                    tests_failed++;
                    $display("FAIL rand_ex_bubble dut%0d n=%0d: got %b want %b", m, n, bub[m], e_bub[m]);
                end
                if (scnt[m] !== 16'(m_stall[m])) begin
                    tests_failed++;
                    $display("FAIL rand_stall_cnt dut%0d n=%0d: got %0d want %0d", m, n, scnt[m], m_stall[m]);
                end
                if (qcnt[m] !== 16'(m_squash[m])) begin
                    tests_failed++;
                    $display("FAIL rand_squash_cnt dut%0d n=%0d: got %0d want %0d", m, n, qcnt[m], m_squash[m]);
                end
            end
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        {id_valid, id_use_rs, id_use_rt, id_wreg, id_is_jump, id_is_branch, id_br_taken} = '0;
        {id_rs, id_rt, id_wdst} = '0;
        model_reset();
        test_reset();
        test_raw_stall();
        test_branch();
        test_jump();
        test_branch_hazard();
        test_reset_mid_squash();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage stall-only pipeline (no forwarding).
- Tracks in-flight register writes and detects RAW hazards against the instruction in ID.
- Drives the IF-stage PC-hold (id_wpcir), wrong-path squash (jmp_stall) and branch-target select (ctrl_branch).
- Inserts bubbles into ID/EX and keeps stall/squash performance counters.

Parameters:
- CTRL_SLOTS, 1, cycles of wrong-path squash after a taken branch/jump (1..3).
- RF_WRITE_THRU, 1, 1 = register file writes in first half-cycle, so the WB entry is not compared; 0 = WB entry compared.
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  5  source register 1 of ID instruction
- id_rt  in  5  source register 2 of ID instruction
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_wreg  in  1  ID instruction writes a register
- id_wdst  in  5  destination register of ID instruction
- id_is_jump  in  1  ID instruction is JMP
- id_is_branch  in  1  ID instruction is BEQ/BNE
- id_br_taken  in  1  branch condition true (valid with id_is_branch)
- id_wpcir  out  1  hold PC and IF/ID (RAW stall)
- jmp_stall  out  1  instruction in ID is wrong-path; treat as NONE
- ctrl_branch  out  1  select nid_pc as next PC this cycle
- ex_bubble  out  1  load NOP into ID/EX this cycle
- stall_cnt  out  CNT_W  cycles with id_wpcir=1
- squash_cnt  out  CNT_W  cycles with jmp_stall=1

Behaviour:
Decided: one clock; reset is synchronous and active-high (clk, rst).

Scoreboard: 3 registered entries {v, dst} for EX, MEM, WB. Each edge:
- WB <= MEM; MEM <= EX.
- EX <= {issue & id_wreg & (id_wdst != 0), id_wdst}.
- issue = id_valid & ~id_wpcir & ~jmp_stall; otherwise EX.v <= 0 (bubble).

Hazard (combinational):
- match(r) = (r != 0) & ((EX.v & EX.dst == r) | (MEM.v & MEM.dst == r) | (~RF_WRITE_THRU & WB.v & WB.dst == r)).
- hazard = id_valid & ~jmp_stall & ((id_use_rs & match(id_rs)) | (id_use_rt & match(id_rt))).
- id_wpcir = hazard.
- Register $0 never causes a hazard.

Control FSM: states IDLE, SQUASH; squash counter width 2.
- IDLE: redirect = issue & (id_is_jump | (id_is_branch & id_br_taken)).
  - ctrl_branch = redirect, combinational in the same cycle.
  - On redirect: go to SQUASH with cnt <= CTRL_SLOTS-1.
- SQUASH: jmp_stall = 1, ctrl_branch = 0, all ID inputs ignored (no hazard, no redirect).
  - If cnt == 0, go to IDLE; else cnt--.
- ex_bubble = hazard | jmp_stall.

Simultaneous events:
- RAW hazard and branch/jump in ID together: hazard wins. No redirect that cycle (branch operands not ready); branch resolves on the first cycle the hazard clears.
- Untaken branch: no redirect, no squash.

Counters:
- stall_cnt increments when id_wpcir = 1.
- squash_cnt increments when jmp_stall = 1.
- Both wrap at 2^CNT_W.

Reset (including mid-stall or mid-squash):
- All scoreboard v <= 0; FSM <= IDLE; cnt <= 0; counters <= 0.
- Outputs on the cycle after reset: id_wpcir = 0, jmp_stall = 0, ctrl_branch = 0 (given id_valid = 0), ex_bubble = 0.

Latency:
- Dependent instruction stalls 2 cycles behind its producer with RF_WRITE_THRU=1, 3 cycles with 0.

Decomposition:
- Shared macro.vh holds: register-zero constant, FSM state encodings (HZ_IDLE, HZ_SQUASH), scoreboard entry field widths.
- One natural sub-module: hz_scoreboard (3-entry shift register plus match(r) compare, two compare ports). The FSM and counters stay in the top module.

Test Plan:
- add $3 then immediately add $4,$3,$1 (RF_WRITE_THRU=1): id_wpcir=1 for exactly 2 cycles, ex_bubble=1 those cycles, stall_cnt=2, then issue.
- Same sequence with RF_WRITE_THRU=0: 3 stall cycles, stall_cnt=3. Producer writing $0 followed by a reader of $0: no stall.
- Taken BEQ, CTRL_SLOTS=1, no hazard: ctrl_branch=1 for 1 cycle; next cycle jmp_stall=1 and ex_bubble=1; hazard inputs ignored; squash_cnt=1. Untaken BEQ: ctrl_branch=0, no squash.
- JMP with CTRL_SLOTS=3: jmp_stall high exactly 3 consecutive cycles; a second JMP presented in ID during SQUASH produces no ctrl_branch.
- BNE reading $5 right after lw $5: ctrl_branch stays 0 while id_wpcir=1 (2 cycles), then ctrl_branch=1 on the first unstalled cycle.
- Assert rst during SQUASH with EX/MEM valid: next cycle jmp_stall=0, id_wpcir=0, counters=0; a following reader of the old dst issues without stall.
